// File: rtl/uart_rpn_pkg.sv
// Shared types, ASCII constants and the hex digit decoder for the UART RPN input path.
package uart_rpn_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF rx synchronizer, mid-bit sampling FSM,
// one-cycle byte_valid and frame_err pulses.
module uart_rx_byte
  import uart_rpn_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  rx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_meta, rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = '0;
          if (rx_sync) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_rpn_input.sv
// Hex-digit accumulator fed by a UART; CR commits the word to DataIn and holds Enter high.
// Optional macro UART_BACKSPACE_EN enables BS/DEL removing the last digit.
module uart_rpn_input
  import uart_rpn_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ENTER_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] DataIn,
  output logic        Enter,
  output logic [2:0]  DigitCount,
  output logic        FrameErr
);

  localparam int unsigned HW = $clog2(ENTER_HOLD + 1);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic [4:0]    dec;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   data_q, data_d;
  logic [2:0]    count_q, count_d;
  logic [HW-1:0] hold_q, hold_d;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (FrameErr)
  );

  assign dec = hex_decode(rx_byte);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      data_q   <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      data_q   <= data_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    data_d   = data_q;
    count_d  = count_q;
    hold_d   = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    if (byte_valid) begin
      if (dec[4]) begin
        shadow_d = {shadow_q[11:0], dec[3:0]};
        count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
      end else if (rx_byte == ASCII_CR) begin
        // A CR during the hold window is dropped so Enter never stretches.
        if (hold_q == '0) begin
          if (count_q != 3'd0) data_d = shadow_q;
          shadow_d = '0;
          count_d  = '0;
          hold_d   = HW'(ENTER_HOLD);
        end
`ifdef UART_BACKSPACE_EN
      end else if ((rx_byte == ASCII_BS || rx_byte == ASCII_DEL) && count_q != 3'd0) begin
        shadow_d = {4'h0, shadow_q[15:4]};
        count_d  = count_q - 3'd1;
`endif
      end
    end
  end

  assign DataIn     = data_q;
  assign Enter      = (hold_q != '0);
  assign DigitCount = count_q;

endmodule
